// File: rtl/sprite_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_arb_pkg
// Brief    : Shared defaults and requester indices for the sprite ROM arbiter.
// Revision : 1.0
// ============================================================================
package sprite_arb_pkg;

  localparam int C_NUM_REQ = 4;
  localparam int C_ADDR_W  = 19;
  localparam int C_DATA_W  = 4;
  localparam int C_ROM_LAT = 1;

  typedef enum logic [1:0] {
    REQ_MARIO = 2'd0,
    REQ_KUBA  = 2'd1,
    REQ_FIRE  = 2'd2,
    REQ_SPARE = 2'd3
  } req_idx_e;

endpackage
`default_nettype wire

// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter_if
// Brief    : Requester and sprite-ROM bus of the arbiter; slave = arbiter side.
// Revision : 1.0
// ============================================================================
interface sprite_rom_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DATA_W  = C_DATA_W
);

  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rom_rd;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport slave (
    input  flush, req, addr, rom_data,
    output gnt, rom_rd, rom_addr, rvalid, rdata
  );

  modport master (
    output flush, req, addr, rom_data,
    input  gnt, rom_rd, rom_addr, rvalid, rdata
  );

endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Round-robin search starting just after the pointer, one-hot result.
// Revision : 1.0
// ============================================================================
module rr_priority_picker
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_cand;

  // Offset NUM_REQ wraps back to the pointer itself, so it is searched last.
  always_comb begin
    o_winner = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = (int'(i_ptr) + off) % NUM_REQ;
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_winner[w_cand] = 1'b1;
        o_idx            = IDX_W'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Brief    : Round-robin sprite ROM arbiter with a grant-tag return pipeline.
// Revision : 1.0
// ============================================================================
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DATA_W  = C_DATA_W,
  parameter int ROM_LAT = C_ROM_LAT
) (
  input  logic                Clk,
  input  logic                Reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_tag [1:ROM_LAT];
  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_winner;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_valid;
  logic               w_hold;
  logic [NUM_REQ-1:0] w_rvalid;

  // Reset and flush act identically: no grant, pointer and tags re-initialised.
  assign w_hold    = Reset | bus.flush;
  assign w_req_eff = w_hold ? '0 : bus.req;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (w_req_eff),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_ff @(posedge Clk) begin
    if (w_hold) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (w_win_valid) begin
      r_ptr <= w_win_idx;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_hold) begin
      for (int s = 1; s <= ROM_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[1] <= w_winner;
      for (int s = 2; s <= ROM_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // The last tag stage is masked too, so a read returning during flush is dropped.
  assign w_rvalid     = w_hold ? '0 : r_tag[ROM_LAT];

  assign bus.gnt      = w_winner;
  assign bus.rom_rd   = w_win_valid;
  assign bus.rom_addr = w_win_valid ? bus.addr[int'(w_win_idx)*ADDR_W +: ADDR_W] : '0;
  assign bus.rvalid   = w_rvalid;
  assign bus.rdata    = (|w_rvalid) ? bus.rom_data : '0;

endmodule
`default_nettype wire

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sprite requesters (index 0 Mario, 1 Kuba, 2 fire, 3 spare).
REQ-002 Parameter ADDR_W, default 19: sprite ROM read-address width.
REQ-003 Parameter DATA_W, default 4: palette-index width of one ROM word.
REQ-004 Parameter ROM_LAT, default 1: cycles from rom_rd/rom_addr to valid rom_data; legal range 1..4.
REQ-005 Clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous discard of in-flight reads, driven by dead_reset.
REQ-008 req  in  NUM_REQ  per-requester read request, level.
REQ-009 addr  in  NUM_REQ*ADDR_W  per-requester read address, slice i = requester i.
REQ-010 gnt  out  NUM_REQ  one-hot-or-zero grant, same cycle as the accepted req.
REQ-011 rom_rd  out  1  ROM read strobe.
REQ-012 rom_addr  out  ADDR_W  ROM read address.
REQ-013 rom_data  in  DATA_W  ROM read data, ROM_LAT cycles after rom_rd.
REQ-014 rvalid  out  NUM_REQ  one-hot-or-zero return tag.
REQ-015 rdata  out  DATA_W  returned palette index.

Function
REQ-016 Each cycle with Reset=0, flush=0 and any req bit set, exactly one gnt bit SHALL assert, combinationally from req and the round-robin pointer.
REQ-017 Winner: first requester with req=1 searching ptr+1, ptr+2, ... modulo NUM_REQ; on grant ptr <= winner index.
REQ-018 Pointer SHALL be unchanged on cycles with no grant.
REQ-019 Grant cycle: rom_rd=1, rom_addr = addr slice of winner; no grant: rom_rd=0, rom_addr=0.
REQ-020 Requester i's request is consumed by gnt[i]; a requester holding req high SHALL receive a new grant on each later win (one read per grant, no bursts).
REQ-021 A ROM_LAT-deep tag shift register SHALL carry the one-hot gnt vector; rvalid = tag stage ROM_LAT, i.e. rvalid[i]=1 exactly ROM_LAT cycles after gnt[i].
REQ-022 rdata = rom_data when any rvalid bit set, else 0.
REQ-023 Throughput: one grant per cycle sustained; returns in grant order; no internal stall.
REQ-024 Fairness: a requester holding req continuously SHALL be granted within NUM_REQ cycles.
REQ-025 flush=1: no grant that cycle (gnt=0, rom_rd=0), all tag stages cleared next edge, ptr <= NUM_REQ-1; reads issued before flush SHALL never produce rvalid.
REQ-026 Grants resume the cycle after flush deasserts.
REQ-027 Reset and flush together: Reset governs; effect identical.
REQ-028 addr of non-requesting or non-granted requesters SHALL not affect any output.

Reset
REQ-029 On Reset=1 at a rising edge: ptr <= NUM_REQ-1, all tag stages <= 0.
REQ-030 While Reset=1: gnt=0, rom_rd=0, rom_addr=0, rvalid=0, rdata=0.
REQ-031 After Reset deasserts, requester 0 SHALL have highest priority for the first grant.

Structure
REQ-032 Package sprite_arb_pkg SHALL hold NUM_REQ, ADDR_W, DATA_W, ROM_LAT defaults and the requester-index enum (REQ_MARIO=0, REQ_KUBA=1, REQ_FIRE=2, REQ_SPARE=3).
REQ-033 Round-robin search SHALL be one sub-module, rr_priority_picker (inputs req, ptr; output one-hot winner and index); tag pipeline and pointer register stay in the top.

Verification
REQ-034 After reset, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; rvalid repeats each one ROM_LAT=1 cycle later.
REQ-035 req=4'b0010, addr[1]=19'd1234, ROM word 1234=4'd9 -> gnt=0010, rom_addr=1234 same cycle; next cycle rvalid=0010, rdata=9.
REQ-036 req=4'b1010 continuous, ROM_LAT=3 -> grants alternate 0010/1000; each rvalid exactly 3 cycles after its gnt.
REQ-037 Grants on 2 consecutive cycles (ROM_LAT=2), flush pulsed on the next cycle -> neither read returns rvalid; gnt=0 during flush; cycle after flush, req=4'b1111 -> gnt=0001.
REQ-038 Reset asserted mid-stream with tags in flight -> rvalid=0 from next cycle; first grant after release to requester 0.
REQ-039 req=0 for 5 cycles -> rom_rd=0, rom_addr=0, rvalid=0, rdata=0, ptr unchanged.
